// File: rtl/small_fifo_pkg.sv
// Shared sizing helpers and read-mode encodings for the small FIFO family.
package small_fifo_pkg;

    localparam int SF_MODE_REG  = 0;
    localparam int SF_MODE_FWFT = 1;

    function automatic int sf_max_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int sf_count_w(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/small_fifo_v3_ctrl.sv
// Pointer, occupancy and status-flag registers for small_fifo_v3.
// SMALL_FIFO_V3_ERR_FLAGS_EN enables the sticky overflow/underflow flags.
module small_fifo_v3_ctrl
    import small_fifo_pkg::*;
#(
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int PROG_FULL_THRESHOLD  = (1 << MAX_DEPTH_BITS) - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic                        rd_en,
    output logic                        wr_acc,
    output logic                        rd_acc,
    output logic [MAX_DEPTH_BITS-1:0]   wr_ptr,
    output logic [MAX_DEPTH_BITS-1:0]   rd_ptr,
    output logic [MAX_DEPTH_BITS:0]     count,
    output logic                        full,
    output logic                        nearly_full,
    output logic                        prog_full,
    output logic                        empty,
    output logic                        prog_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int CW = sf_count_w(MAX_DEPTH_BITS);
    localparam logic [CW-1:0] DEPTH_C = CW'(sf_max_depth(MAX_DEPTH_BITS));
    localparam logic [CW-1:0] NF_C    = CW'(sf_max_depth(MAX_DEPTH_BITS) - 1);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESHOLD);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESHOLD);

    logic [CW-1:0] count_nxt;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Flags come from count_nxt so they are registered yet never lag count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            nearly_full <= 1'b0;
            prog_full   <= 1'b0;
            empty       <= 1'b1;
            prog_empty  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            full        <= (count_nxt == DEPTH_C);
            nearly_full <= (count_nxt >= NF_C);
            prog_full   <= (count_nxt >= PF_C);
            empty       <= (count_nxt == '0);
            prog_empty  <= (count_nxt <= PE_C);
        end
    end

`ifdef SMALL_FIFO_V3_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: rtl/small_fifo_v3.sv
// Synchronous FIFO with registered or fall-through read, programmable thresholds and count.
// Define SMALL_FIFO_V3_ERR_FLAGS_EN for sticky overflow/underflow flags (tied 0 otherwise).
module small_fifo_v3
    import small_fifo_pkg::*;
#(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int FWFT                 = SF_MODE_REG,
    parameter int PROG_FULL_THRESHOLD  = (1 << MAX_DEPTH_BITS) - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          din,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      nearly_full,
    output logic                      prog_full,
    output logic                      empty,
    output logic                      prog_empty,
    output logic [MAX_DEPTH_BITS:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int DEPTH = sf_max_depth(MAX_DEPTH_BITS);

    if (PROG_FULL_THRESHOLD < 1 || PROG_FULL_THRESHOLD > DEPTH ||
        PROG_EMPTY_THRESHOLD < 0 || PROG_EMPTY_THRESHOLD >= DEPTH) begin : g_bad_threshold
        $error("small_fifo_v3: threshold parameter out of range");
    end

    logic                      wr_acc, rd_acc;
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0]          mem [DEPTH];

    small_fifo_v3_ctrl #(
        .MAX_DEPTH_BITS      (MAX_DEPTH_BITS),
        .PROG_FULL_THRESHOLD (PROG_FULL_THRESHOLD),
        .PROG_EMPTY_THRESHOLD(PROG_EMPTY_THRESHOLD)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_acc     (wr_acc),
        .rd_acc     (rd_acc),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .full       (full),
        .nearly_full(nearly_full),
        .prog_full  (prog_full),
        .empty      (empty),
        .prog_empty (prog_empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    if (FWFT == SF_MODE_FWFT) begin : g_fwft
        // Masked while empty so stale storage never shows and reset reads as 0.
        assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        always_ff @(posedge clk) begin
            if (reset)       dout <= '0;
            else if (rd_acc) dout <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_small_fifo_v3.sv
// Directed bench for small_fifo_v3: registered-read and fall-through instances side by side.
module tb_small_fifo_v3;

`ifdef SMALL_FIFO_V3_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = '0, f_din = '0;
    logic       wr_en = 1'b0, rd_en = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] dout, f_dout;
    logic       full, nearly_full, prog_full, empty, prog_empty, overflow, underflow;
    logic       f_full, f_nearly_full, f_prog_full, f_empty, f_prog_empty, f_overflow, f_underflow;
    logic [2:0] count, f_count;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    small_fifo_v3 #(.WIDTH(8), .MAX_DEPTH_BITS(2), .FWFT(0),
                    .PROG_FULL_THRESHOLD(3), .PROG_EMPTY_THRESHOLD(1)) dut (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .full(full), .nearly_full(nearly_full), .prog_full(prog_full),
        .empty(empty), .prog_empty(prog_empty), .count(count),
        .overflow(overflow), .underflow(underflow));

    small_fifo_v3 #(.WIDTH(8), .MAX_DEPTH_BITS(2), .FWFT(1),
                    .PROG_FULL_THRESHOLD(3), .PROG_EMPTY_THRESHOLD(1)) dut_f (
        .clk(clk), .reset(reset), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .dout(f_dout), .full(f_full), .nearly_full(f_nearly_full), .prog_full(f_prog_full),
        .empty(f_empty), .prog_empty(f_prog_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input int c, input logic e, input logic pe,
                         input logic nf, input logic pf, input logic f);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".prog_empty"}, 32'(prog_empty), 32'(pe));
        chk({tag, ".nearly_full"}, 32'(nearly_full), 32'(nf));
        chk({tag, ".prog_full"}, 32'(prog_full), 32'(pf));
        chk({tag, ".full"}, 32'(full), 32'(f));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        flags("rst", 0, 1, 1, 0, 0, 0);
        chk("rst.dout", 32'(dout), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
        chk("rst.unf", 32'(underflow), 32'h0);
        chk("rst.f_dout", 32'(f_dout), 32'h0);
        chk("rst.f_empty", 32'(f_empty), 32'h1);

        // 1: fill to full, flag thresholds, 5th write dropped
        wr_en = 1'b1;
        din = 8'h11; tick(); flags("w1", 1, 0, 1, 0, 0, 0);
        din = 8'h22; tick(); flags("w2", 2, 0, 0, 0, 0, 0);
        din = 8'h33; tick(); flags("w3", 3, 0, 0, 1, 1, 0);
        din = 8'h44; tick(); flags("w4", 4, 0, 0, 1, 1, 1);
        din = 8'h55; tick(); flags("w5", 4, 0, 0, 1, 1, 1);
        chk("w5.ovf", 32'(overflow), 32'(ERR));
        wr_en = 1'b0;

        // 2: registered-read drain, extra read holds dout
        rd_en = 1'b1;
        tick(); chk("r1.dout", 32'(dout), 32'h11);
        tick(); chk("r2.dout", 32'(dout), 32'h22);
        tick(); chk("r3.dout", 32'(dout), 32'h33); flags("r3", 1, 0, 1, 0, 0, 0);
        tick(); chk("r4.dout", 32'(dout), 32'h44); flags("r4", 0, 1, 1, 0, 0, 0);
        tick(); chk("r5.dout", 32'(dout), 32'h44); chk("r5.count", 32'(count), 32'h0);
        chk("r5.unf", 32'(underflow), 32'(ERR));
        chk("r5.ovf", 32'(overflow), 32'(ERR));
        rd_en = 1'b0;

        // 3: fall-through instance
        f_wr = 1'b1; f_din = 8'hA5; tick(); f_wr = 1'b0;
        chk("ft1.empty", 32'(f_empty), 32'h0);
        chk("ft1.dout", 32'(f_dout), 32'hA5);
        tick(); chk("ft2.dout", 32'(f_dout), 32'hA5);
        f_rd = 1'b1; tick(); f_rd = 1'b0;
        chk("ft3.empty", 32'(f_empty), 32'h1);
        chk("ft3.count", 32'(f_count), 32'h0);
        f_wr = 1'b1; f_din = 8'h5A; tick(); f_din = 8'h6B; tick(); f_wr = 1'b0;
        chk("ft4.dout", 32'(f_dout), 32'h5A);
        f_rd = 1'b1; tick(); f_rd = 1'b0;
        chk("ft5.dout", 32'(f_dout), 32'h6B);
        chk("ft5.count", 32'(f_count), 32'h1);

        // 4: steady simultaneous traffic at count 2, pointers wrap
        wr_en = 1'b1;
        din = 8'hA0; tick();
        din = 8'hA1; tick();
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'hB0 + 8'(i);
            tick();
            chk("sim.dout", 32'(dout), (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'hB0 + 32'(i - 2));
            flags("sim", 2, 0, 0, 0, 0, 0);
        end
        wr_en = 1'b0;
        tick(); chk("simd1.dout", 32'(dout), 32'hB6);
        tick(); chk("simd2.dout", 32'(dout), 32'hB7); chk("simd2.empty", 32'(empty), 32'h1);
        rd_en = 1'b0;

        // 5: full + both -> read only; empty + both -> write only
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'hC0 + 8'(i);
            tick();
        end
        chk("fb0.full", 32'(full), 32'h1);
        din = 8'hEE; rd_en = 1'b1; tick();
        chk("fb.count", 32'(count), 32'h3);
        chk("fb.dout", 32'(dout), 32'hC0);
        chk("fb.full", 32'(full), 32'h0);
        wr_en = 1'b0;
        tick(); chk("fbr1.dout", 32'(dout), 32'hC1);
        tick(); chk("fbr2.dout", 32'(dout), 32'hC2);
        tick(); chk("fbr3.dout", 32'(dout), 32'hC3); chk("fbr3.empty", 32'(empty), 32'h1);
        wr_en = 1'b1; din = 8'hD1; tick();
        chk("eb.count", 32'(count), 32'h1);
        chk("eb.dout", 32'(dout), 32'hC3);
        wr_en = 1'b0; tick();
        chk("ebr.dout", 32'(dout), 32'hD1);
        rd_en = 1'b0;

        // 6: reset mid-stream at count 3 clears contents and sticky flags
        wr_en = 1'b1;
        din = 8'h71; tick(); din = 8'h72; tick(); din = 8'h73; tick();
        wr_en = 1'b0;
        chk("pre.count", 32'(count), 32'h3);
        chk("pre.ovf", 32'(overflow), 32'(ERR));
        reset = 1'b1; tick(); reset = 1'b0;
        flags("mrst", 0, 1, 1, 0, 0, 0);
        chk("mrst.ovf", 32'(overflow), 32'h0);
        chk("mrst.unf", 32'(underflow), 32'h0);
        chk("mrst.dout", 32'(dout), 32'h0);
        wr_en = 1'b1; din = 8'h99; tick(); wr_en = 1'b0;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("post.dout", 32'(dout), 32'h99);
        chk("post.empty", 32'(empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
